mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, rising-edge active.
REQ-002 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: rdy_in  input  1  global ready; 0 freezes the block.
REQ-004 SHALL have ports: if_re  input  1  fetch-side byte read request, level, held for the whole transaction.
REQ-005 SHALL have ports: if_addr  input  32  fetch-side byte address.
REQ-006 SHALL have ports: if_rdata  output  8  fetch-side read byte.
REQ-007 SHALL have ports: if_stall  output  1  fetch side requesting but not bus owner.
REQ-008 SHALL have ports: mem_re, mem_we  input  1 each  memory-stage read / write request, level, mutually exclusive.
REQ-009 SHALL have ports: mem_addr  input  32  memory-stage byte address.
REQ-010 SHALL have ports: mem_wdata  input  8  memory-stage write byte.
REQ-011 SHALL have ports: mem_rdata  output  8  memory-stage read byte.
REQ-012 SHALL have ports: mem_stall  output  1  memory stage requesting but not bus owner.
REQ-013 SHALL have ports: ram_a  output  18  RAM byte address (registered).
REQ-014 SHALL have ports: ram_dout, ram_wr  output  8, 1  RAM write data and write strobe (registered).
REQ-015 SHALL have ports: ram_din  input  8  RAM read byte, valid one cycle after ram_a.
REQ-016 SHALL have parameter: ADDR_W, default 18, RAM address width; ram_a = requester address[ADDR_W-1:0].

Function
REQ-017 SHALL hold owner state in {IDLE, OWN_IF, OWN_MEM}, updated on clk rising edge only when rdy_in=1.
REQ-018 SHALL transition IDLE->OWN_MEM when mem_re|mem_we; else IDLE->OWN_IF when if_re; else stay IDLE. MEM wins simultaneous requests.
REQ-019 SHALL hold OWN_MEM while mem_re|mem_we; on drop: ->OWN_IF if if_re, else ->IDLE (direct handoff, no idle bubble).
REQ-020 SHALL hold OWN_IF while if_re; on drop: ->OWN_MEM if mem_re|mem_we, else ->IDLE. No preemption of an active owner.
REQ-021 SHALL drive stalls combinationally: if_stall = if_re & (owner!=OWN_IF); mem_stall = (mem_re|mem_we) & (owner!=OWN_MEM).
REQ-022 SHALL, each enabled edge, register ram_a from the owner's address, ram_dout from mem_wdata (OWN_MEM) else 0, ram_wr = (owner==OWN_MEM)&mem_we.
REQ-023 SHALL register ram_a=0, ram_dout=0, ram_wr=0 on edges where owner is IDLE.
REQ-024 SHALL evaluate REQ-022/023 with the owner value before the edge; newly granted requester reaches RAM one edge after grant.
REQ-025 SHALL give read latency 2 edges: requester address stable across edges e and e+1 -> ram_a updated at e, byte on ram_din after e+1.
REQ-026 SHALL route ram_din combinationally to the rdata of the owner; non-owner rdata = 0; both 0 in IDLE.
REQ-027 SHALL, when rdy_in=0, hold owner, ram_a, ram_dout; force ram_wr=0 registered at that edge; stalls remain combinational per REQ-021.
REQ-028 SHALL never assert ram_wr for a fetch-side request or when mem_re alone is active.
REQ-029 SHALL treat mem_re & mem_we both high as a write.

Reset
REQ-030 SHALL, on rst=1 (asynchronous, including mid-transaction), set owner=IDLE, ram_a=0, ram_dout=0, ram_wr=0; if_rdata=mem_rdata=0 while rst=1.
REQ-031 SHALL resume arbitration per REQ-018 on the first enabled edge after rst falls; any interrupted transaction is dropped.

Verification
REQ-032 SHALL cover: idle, if_re=1, if_addr=0x104, ram_din returns 0x13 -> owner OWN_IF after edge 1, ram_a=0x104 after edge 2, if_rdata=0x13 after edge 3, if_stall=0 from edge 1.
REQ-033 SHALL cover: if_re and mem_re rise together -> OWN_MEM granted, if_stall=1, mem_stall=0; mem_re drops with if_re still high -> OWN_IF same edge, if_stall=0.
REQ-034 SHALL cover: mem_we=1, mem_addr 0x1000..0x1003, mem_wdata 0xEF,0xBE,0xAD,0xDE each held 1 cycle -> ram_wr=1 four cycles, ram_a 0x1000..0x1003 with matching ram_dout, then ram_wr=0.
REQ-035 SHALL cover: OWN_IF active, mem_we rises -> mem_stall=1, ram_wr stays 0 until if_re drops; then OWN_MEM and first write next edge.
REQ-036 SHALL cover: rdy_in=0 for 3 cycles mid-write -> ram_wr=0, ram_a held, owner unchanged; rdy_in=1 resumes same owner.
REQ-037 SHALL cover: rst pulse mid OWN_MEM read -> immediate owner IDLE, ram_a=0, mem_rdata=0; with mem_re still high, OWN_MEM granted on first edge after rst falls.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-wide single-port RAM arbiter between a fetch requester and a memory-stage requester.
// The memory stage wins simultaneous requests; an active owner is never preempted.
module mem_ctrl #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_in,
  input  logic              if_re,
  input  logic [31:0]       if_addr,
  output logic [7:0]        if_rdata,
  output logic              if_stall,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [7:0]        mem_wdata,
  output logic [7:0]        mem_rdata,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_IF  = 2'd1,
    OWN_MEM = 2'd2
  } owner_e;

  owner_e owner, owner_nxt;

  logic              mem_req;
  logic [ADDR_W-1:0] ram_a_nxt;
  logic [7:0]        ram_dout_nxt;
  logic              ram_wr_nxt;

  assign mem_req = mem_re | mem_we;

  // NOTE: every output of this block gets a default before the case, so no path leaves a latch.
  always_comb begin
    owner_nxt = owner;
    case (owner)
      IDLE: begin
        if (mem_req)    owner_nxt = OWN_MEM;
        else if (if_re) owner_nxt = OWN_IF;
      end
      OWN_MEM: begin
        if (!mem_req) owner_nxt = if_re ? OWN_IF : IDLE;
      end
      OWN_IF: begin
        if (!if_re) owner_nxt = mem_req ? OWN_MEM : IDLE;
      end
      default: owner_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         owner <= IDLE;
    else if (rdy_in) owner <= owner_nxt;
  end

  // RAM-side values come from the owner before the edge, so a new grant reaches RAM one edge later.
  always_comb begin
    ram_a_nxt    = '0;
    ram_dout_nxt = '0;
    ram_wr_nxt   = 1'b0;
    case (owner)
      OWN_IF: ram_a_nxt = if_addr[ADDR_W-1:0];
      OWN_MEM: begin
        ram_a_nxt    = mem_addr[ADDR_W-1:0];
        ram_dout_nxt = mem_wdata;
        ram_wr_nxt   = mem_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_a    <= '0;
      ram_dout <= '0;
      ram_wr   <= 1'b0;
    end else if (rdy_in) begin
      ram_a    <= ram_a_nxt;
      ram_dout <= ram_dout_nxt;
      ram_wr   <= ram_wr_nxt;
    end else begin
      // Frozen: address and data hold, but a held strobe would repeat the write.
      ram_wr <= 1'b0;
    end
  end

  assign if_stall  = if_re   & (owner != OWN_IF);
  assign mem_stall = mem_req & (owner != OWN_MEM);

  always_comb begin
    if_rdata  = '0;
    mem_rdata = '0;
    case (owner)
      OWN_IF:  if_rdata  = ram_din;
      OWN_MEM: mem_rdata = ram_din;
      default: ;
    endcase
  end

  // Address bits above the RAM width are intentionally ignored.
  generate
    if (ADDR_W < 32) begin : g_unused_hi
      logic unused_addr_hi;
      assign unused_addr_hi = &{1'b0, if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};
    end
  endgenerate

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: arbitration vector table, read/write scoreboards,
// and hand-written freeze and mid-transaction reset sequences against a behavioural RAM.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy_in;
  logic        if_re;
  logic [31:0] if_addr;
  logic [7:0]  if_rdata;
  logic        if_stall;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_stall;
  logic [17:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  int n_checks = 0;
  int n_errors = 0;

  mem_ctrl #(.ADDR_W(18)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy_in    (rdy_in),
    .if_re     (if_re),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_stall  (if_stall),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_stall (mem_stall),
    .ram_a     (ram_a),
    .ram_dout  (ram_dout),
    .ram_wr    (ram_wr),
    .ram_din   (ram_din)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM: read byte appears one edge after the address.
  logic [7:0] ram [0:(1<<18)-1];

  function automatic logic [7:0] pattern(input logic [17:0] a);
    return (a[7:0] + 8'h0F) ^ a[17:10];
  endfunction

  always @(posedge clk) begin
    ram_din <= ram[ram_a];
    if (ram_wr) ram[ram_a] <= ram_dout;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rdy, input logic ire, input logic mre, input logic mwe,
                       input logic [31:0] ia, input logic [31:0] ma, input logic [7:0] wd);
    rdy_in    = rdy;
    if_re     = ire;
    mem_re    = mre;
    mem_we    = mwe;
    if_addr   = ia;
    mem_addr  = ma;
    mem_wdata = wd;
  endtask

  typedef struct {
    logic        rdy, ire, mre, mwe;
    logic [31:0] ia, ma;
    logic [7:0]  wd;
    logic        e_if_stall, e_mem_stall;
    logic [17:0] e_ram_a;
    logic [7:0]  e_ram_dout;
    logic        e_ram_wr;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic ire, input logic mre, input logic mwe,
                              input logic [31:0] ia, input logic [31:0] ma, input logic [7:0] wd,
                              input logic eis, input logic ems, input logic [17:0] ea,
                              input logic [7:0] ed, input logic ew);
    vec_t v;
    v.rdy = rdy; v.ire = ire; v.mre = mre; v.mwe = mwe;
    v.ia = ia; v.ma = ma; v.wd = wd;
    v.e_if_stall = eis; v.e_mem_stall = ems;
    v.e_ram_a = ea; v.e_ram_dout = ed; v.e_ram_wr = ew;
    return v;
  endfunction

  typedef struct {
    logic [17:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0] rd_q[$];
  wr_t        wr_q[$];

  // Streamed read on the fetch side: expected bytes are queued as addresses are driven
  // and compared two edges later when they surface on if_rdata.
  task automatic read_burst(input logic [31:0] base, input int n);
    logic [7:0] exp;
    drive(1, 1, 0, 0, base, 32'h0, 8'h00);
    step();
    check("rd_grant_if_stall", if_stall, 0);
    for (int i = 0; i < n; i++) begin
      if_addr = base + i;
      rd_q.push_back(pattern(if_addr[17:0]));
      step();
      if (i == 0) check("rd_first_ram_a", ram_a, base[17:0]);
      if (rd_q.size() == 2) begin
        exp = rd_q.pop_front();
        check($sformatf("rd_data_%0d", i - 1), if_rdata, exp);
      end
    end
    while (rd_q.size() > 0) begin
      step();
      exp = rd_q.pop_front();
      check("rd_data_last", if_rdata, exp);
    end
    check("rd_mem_rdata_zero", mem_rdata, 0);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 8'h00);
    step();
    step();
  endtask

  vec_t vecs[18];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] wa[4];
    logic [7:0]  wd[4];
    wr_t         w;
    int          wr_seen;

    for (int a = 0; a < (1 << 18); a++) ram[a] = pattern(a[17:0]);

    // ---------------- reset state ----------------
    rst = 1'b1;
    drive(1, 0, 1, 0, 32'h0, 32'h0, 8'h00);
    step();
    check("rst_ram_a", ram_a, 0);
    check("rst_ram_dout", ram_dout, 0);
    check("rst_ram_wr", ram_wr, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_mem_stall", mem_stall, 1);
    mem_re = 1'b0;
    rst    = 1'b0;
    step();

    // ---------------- arbitration vector table ----------------
    //              rdy ire mre mwe if_addr  mem_addr       wdata  ifs mems ram_a     dout   wr
    vecs[0]  = mk(1, 0, 0, 0, 32'h200, 32'h300,       8'h00, 0, 0, 18'h00000, 8'h00, 0);
    vecs[1]  = mk(1, 1, 1, 0, 32'h200, 32'h300,       8'h00, 1, 0, 18'h00000, 8'h00, 0);
    vecs[2]  = mk(1, 1, 1, 0, 32'h200, 32'h300,       8'h00, 1, 0, 18'h00300, 8'h00, 0);
    vecs[3]  = mk(1, 1, 0, 0, 32'h200, 32'h300,       8'h00, 0, 0, 18'h00300, 8'h00, 0);
    vecs[4]  = mk(1, 1, 0, 0, 32'h200, 32'h300,       8'h00, 0, 0, 18'h00200, 8'h00, 0);
    vecs[5]  = mk(1, 1, 0, 1, 32'h200, 32'h2000,      8'h5A, 0, 1, 18'h00200, 8'h00, 0);
    vecs[6]  = mk(1, 1, 0, 1, 32'h200, 32'h2000,      8'h5A, 0, 1, 18'h00200, 8'h00, 0);
    vecs[7]  = mk(1, 0, 0, 1, 32'h200, 32'h2000,      8'h5A, 0, 0, 18'h00200, 8'h00, 0);
    vecs[8]  = mk(1, 0, 0, 1, 32'h200, 32'h2000,      8'h5A, 0, 0, 18'h02000, 8'h5A, 1);
    vecs[9]  = mk(1, 0, 0, 0, 32'h200, 32'h2000,      8'h5A, 0, 0, 18'h02000, 8'h5A, 0);
    vecs[10] = mk(1, 0, 0, 0, 32'h200, 32'h2000,      8'h5A, 0, 0, 18'h00000, 8'h00, 0);
    vecs[11] = mk(1, 0, 1, 1, 32'h200, 32'hFFFF_FFFF, 8'h77, 0, 0, 18'h00000, 8'h00, 0);
    vecs[12] = mk(1, 0, 1, 1, 32'h200, 32'hFFFF_FFFF, 8'h77, 0, 0, 18'h3FFFF, 8'h77, 1);
    vecs[13] = mk(0, 0, 1, 1, 32'h200, 32'hFFFF_FFFF, 8'h77, 0, 0, 18'h3FFFF, 8'h77, 0);
    vecs[14] = mk(0, 1, 0, 0, 32'h200, 32'hFFFF_FFFF, 8'h77, 1, 0, 18'h3FFFF, 8'h77, 0);
    vecs[15] = mk(1, 1, 0, 0, 32'h200, 32'hFFFF_FFFF, 8'h77, 0, 0, 18'h3FFFF, 8'h77, 0);
    vecs[16] = mk(1, 0, 0, 0, 32'h200, 32'hFFFF_FFFF, 8'h77, 0, 0, 18'h00200, 8'h00, 0);
    vecs[17] = mk(1, 0, 0, 0, 32'h200, 32'hFFFF_FFFF, 8'h77, 0, 0, 18'h00000, 8'h00, 0);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rdy, vecs[i].ire, vecs[i].mre, vecs[i].mwe, vecs[i].ia, vecs[i].ma, vecs[i].wd);
      step();
      check($sformatf("vec%0d_if_stall", i),  if_stall,  vecs[i].e_if_stall);
      check($sformatf("vec%0d_mem_stall", i), mem_stall, vecs[i].e_mem_stall);
      check($sformatf("vec%0d_ram_a", i),     ram_a,     vecs[i].e_ram_a);
      check($sformatf("vec%0d_ram_dout", i),  ram_dout,  vecs[i].e_ram_dout);
      check($sformatf("vec%0d_ram_wr", i),    ram_wr,    vecs[i].e_ram_wr);
    end

    // ---------------- fetch reads (0x104 -> 0x13), then upper address bits ignored ----------------
    check("pattern_0x104", pattern(18'h00104), 32'h13);
    read_burst(32'h0000_0104, 4);
    read_burst(32'hFFFC_0200, 2);

    // ---------------- four-byte write burst via scoreboard ----------------
    wa[0] = 32'h1000; wa[1] = 32'h1001; wa[2] = 32'h1002; wa[3] = 32'h1003;
    wd[0] = 8'hEF;    wd[1] = 8'hBE;    wd[2] = 8'hAD;    wd[3] = 8'hDE;
    wr_seen = 0;
    drive(1, 0, 0, 1, 32'h0, wa[0], wd[0]);
    step();
    check("wr_grant_mem_stall", mem_stall, 0);
    check("wr_grant_ram_wr", ram_wr, 0);
    for (int i = 0; i < 4; i++) begin
      mem_addr  = wa[i];
      mem_wdata = wd[i];
      w.a = wa[i][17:0];
      w.d = wd[i];
      wr_q.push_back(w);
      step();
      if (ram_wr === 1'b1) begin
        wr_seen++;
        if (wr_q.size() == 0) begin
          check("wr_unexpected_strobe", ram_wr, 0);
        end else begin
          w = wr_q.pop_front();
          check($sformatf("wr%0d_ram_a", i), ram_a, w.a);
          check($sformatf("wr%0d_ram_dout", i), ram_dout, w.d);
        end
      end
    end
    mem_we = 1'b0;
    step();
    check("wr_end_ram_wr", ram_wr, 0);
    check("wr_strobe_count", wr_seen, 4);
    check("wr_q_drained", wr_q.size(), 0);
    for (int i = 0; i < 4; i++) check($sformatf("wr%0d_ram_content", i), ram[wa[i][17:0]], wd[i]);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 8'h00);
    step();

    // ---------------- freeze for three cycles mid-write ----------------
    drive(1, 0, 0, 1, 32'h0, 32'h1800, 8'h11);
    step();
    step();
    check("frz_pre_ram_wr", ram_wr, 1);
    check("frz_pre_ram_a", ram_a, 18'h01800);
    drive(0, 1, 0, 1, 32'h400, 32'h1801, 8'h22);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("frz%0d_ram_wr", i), ram_wr, 0);
      check($sformatf("frz%0d_ram_a", i), ram_a, 18'h01800);
      check($sformatf("frz%0d_ram_dout", i), ram_dout, 8'h11);
      check($sformatf("frz%0d_mem_stall", i), mem_stall, 0);
      check($sformatf("frz%0d_if_stall", i), if_stall, 1);
    end
    rdy_in = 1'b1;
    step();
    check("frz_resume_ram_wr", ram_wr, 1);
    check("frz_resume_ram_a", ram_a, 18'h01801);
    check("frz_resume_ram_dout", ram_dout, 8'h22);
    check("frz_resume_if_stall", if_stall, 1);
    mem_we = 1'b0;
    step();
    check("frz_handoff_ram_wr", ram_wr, 0);
    check("frz_handoff_if_stall", if_stall, 0);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 8'h00);
    step();
    step();

    // ---------------- reset pulse during a memory-side read ----------------
    drive(1, 0, 1, 0, 32'h0, 32'h2345, 8'h00);
    step();
    step();
    step();
    check("rstmid_pre_mem_rdata", mem_rdata, pattern(18'h02345));
    check("rstmid_pre_if_rdata", if_rdata, 0);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_ram_a", ram_a, 0);
    check("rstmid_mem_rdata", mem_rdata, 0);
    check("rstmid_mem_stall", mem_stall, 1);
    step();
    check("rstmid_held_mem_stall", mem_stall, 1);
    rst = 1'b0;
    step();
    check("rstmid_regrant_mem_stall", mem_stall, 0);
    check("rstmid_regrant_ram_a", ram_a, 0);
    step();
    check("rstmid_ram_a_again", ram_a, 18'h02345);
    step();
    check("rstmid_mem_rdata_again", mem_rdata, pattern(18'h02345));
    drive(1, 0, 0, 0, 32'h0, 32'h0, 8'h00);
    step();
    step();
    check("final_idle_ram_a", ram_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
